// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode/funct constants and control enums for the MIPS core
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI
  } alu_op_e;

  typedef enum logic [1:0] {EXT_SIGN, EXT_ZERO, EXT_UPPER} ext_mode_e;

  function automatic logic [31:0] extend_imm(input logic [15:0] imm, input ext_mode_e mode);
    case (mode)
      EXT_ZERO:  extend_imm = {16'h0000, imm};
      EXT_UPPER: extend_imm = {imm, 16'h0000};
      default:   extend_imm = {{16{imm[15]}}, imm};
    endcase
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// rtl/mips_regfile.sv - GPR file: two async read ports, one sync write port, sync clear
module mips_regfile #(
  parameter int REG_COUNT = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);
  localparam int AW = $clog2(REG_COUNT);

  logic [31:0] regs_q [REG_COUNT];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (we_i && waddr_i != 5'd0) begin
      regs_q[waddr_i[AW-1:0]] <= wdata_i;
    end
  end

  // Register 0 is forced to zero on the read side, so its storage is never observed.
  assign rdata1_o = (raddr1_i == 5'd0) ? 32'h0 : regs_q[raddr1_i[AW-1:0]];
  assign rdata2_o = (raddr2_i == 5'd0) ? 32'h0 : regs_q[raddr2_i[AW-1:0]];

endmodule

// File: rtl/mips_single_cycle_cpu.sv
// rtl/mips_single_cycle_cpu.sv - single-cycle MIPS core: PC, decode, ALU, next-PC, write-back
module mips_single_cycle_cpu
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          REG_COUNT = 32
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] Instruction,
  input  logic [31:0] DataToWd,
  output logic [31:0] addr,
  output logic [31:0] ALU_result,
  output logic [31:0] Ext_Imm,
  output logic [31:0] Out1,
  output logic [31:0] Out2,
  output logic        MemWrite,
  output logic        MemtoReg
);
  logic [31:0] pc_q, pc_d, pc_plus4, sext_imm, alu_a, alu_b, wb_data;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt, wb_addr;
  logic        reg_write, reg_dst_rd, alu_src_imm, mem_write_dec, is_beq, is_bne, is_j;
  alu_op_e     alu_op;
  ext_mode_e   ext_mode;

  assign opcode = Instruction[31:26];
  assign rs     = Instruction[25:21];
  assign rt     = Instruction[20:16];
  assign rd     = Instruction[15:11];
  assign shamt  = Instruction[10:6];
  assign funct  = Instruction[5:0];

  always_comb begin
    reg_write     = 1'b0;
    reg_dst_rd    = 1'b0;
    alu_src_imm   = 1'b0;
    mem_write_dec = 1'b0;
    MemtoReg      = 1'b0;
    is_beq        = 1'b0;
    is_bne        = 1'b0;
    is_j          = 1'b0;
    alu_op        = ALU_ADD;
    ext_mode      = EXT_SIGN;
    case (opcode)
      OP_RTYPE: begin
        reg_dst_rd = 1'b1;
        reg_write  = 1'b1;
        case (funct)
          F_ADD, F_ADDU: alu_op = ALU_ADD;
          F_SUB, F_SUBU: alu_op = ALU_SUB;
          F_AND:         alu_op = ALU_AND;
          F_OR:          alu_op = ALU_OR;
          F_XOR:         alu_op = ALU_XOR;
          F_NOR:         alu_op = ALU_NOR;
          F_SLT:         alu_op = ALU_SLT;
          F_SLL:         alu_op = ALU_SLL;
          F_SRL:         alu_op = ALU_SRL;
          default:       reg_write = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin reg_write = 1'b1; alu_src_imm = 1'b1; end
      OP_SLTI: begin reg_write = 1'b1; alu_src_imm = 1'b1; alu_op = ALU_SLT; end
      OP_ANDI: begin reg_write = 1'b1; alu_src_imm = 1'b1; alu_op = ALU_AND; ext_mode = EXT_ZERO; end
      OP_ORI:  begin reg_write = 1'b1; alu_src_imm = 1'b1; alu_op = ALU_OR;  ext_mode = EXT_ZERO; end
      OP_XORI: begin reg_write = 1'b1; alu_src_imm = 1'b1; alu_op = ALU_XOR; ext_mode = EXT_ZERO; end
      OP_LUI:  begin reg_write = 1'b1; alu_src_imm = 1'b1; alu_op = ALU_LUI; ext_mode = EXT_UPPER; end
      OP_LW:   begin reg_write = 1'b1; alu_src_imm = 1'b1; MemtoReg = 1'b1; end
      OP_SW:   begin alu_src_imm = 1'b1; mem_write_dec = 1'b1; end
      OP_BEQ:  begin is_beq = 1'b1; alu_op = ALU_SUB; end
      OP_BNE:  begin is_bne = 1'b1; alu_op = ALU_SUB; end
      OP_J:    is_j = 1'b1;
      default: ;
    endcase
  end

  assign sext_imm = {{16{Instruction[15]}}, Instruction[15:0]};
  assign Ext_Imm  = extend_imm(Instruction[15:0], ext_mode);
  assign MemWrite = mem_write_dec & ~Reset;

  // Shifts take their operand from rt; the amount comes from the shamt field.
  assign alu_a = (alu_op == ALU_SLL || alu_op == ALU_SRL) ? Out2 : Out1;
  assign alu_b = alu_src_imm ? Ext_Imm : Out2;

  always_comb begin
    case (alu_op)
      ALU_SUB: ALU_result = alu_a - alu_b;
      ALU_AND: ALU_result = alu_a & alu_b;
      ALU_OR:  ALU_result = alu_a | alu_b;
      ALU_XOR: ALU_result = alu_a ^ alu_b;
      ALU_NOR: ALU_result = ~(alu_a | alu_b);
      ALU_SLT: ALU_result = {31'h0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLL: ALU_result = alu_a << shamt;
      ALU_SRL: ALU_result = alu_a >> shamt;
      ALU_LUI: ALU_result = alu_b;
      default: ALU_result = alu_a + alu_b;
    endcase
  end

  assign wb_addr = reg_dst_rd ? rd : rt;
  assign wb_data = MemtoReg ? DataToWd : ALU_result;

  mips_regfile #(.REG_COUNT(REG_COUNT)) u_regfile (
    .clk_i    (Clock),
    .rst_i    (Reset),
    .we_i     (reg_write & ~Reset),
    .waddr_i  (wb_addr),
    .wdata_i  (wb_data),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (Out1),
    .rdata2_o (Out2)
  );

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_plus4;
    if ((is_beq && Out1 == Out2) || (is_bne && Out1 != Out2)) pc_d = pc_plus4 + (sext_imm << 2);
    else if (is_j) pc_d = {pc_plus4[31:28], Instruction[25:0], 2'b00};
  end

  always_ff @(posedge Clock) begin
    if (Reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign addr = pc_q;

endmodule

// File: tb/tb_mips_single_cycle_cpu.sv
// tb/tb_mips_single_cycle_cpu.sv - directed vector bench for the single-cycle MIPS core
module tb_mips_single_cycle_cpu;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] Instruction, DataToWd;
  logic [31:0] addr, ALU_result, Ext_Imm, Out1, Out2;
  logic        MemWrite, MemtoReg;

  int n_vec = 0;
  int n_bad = 0;

  always #5 Clock = ~Clock;

  mips_single_cycle_cpu dut (
    .Clock(Clock), .Reset(Reset), .Instruction(Instruction), .DataToWd(DataToWd),
    .addr(addr), .ALU_result(ALU_result), .Ext_Imm(Ext_Imm), .Out1(Out1), .Out2(Out2),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg)
  );

  typedef struct {
    logic [31:0] instr, dwd, addr, alu, ext, out1, out2;
    logic        mw, m2r, chk_alu;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int fn);
    logic [31:0] w;
    w = {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
    return w;
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    logic [31:0] w;
    w = {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    return w;
  endfunction

  task automatic add(input logic [31:0] instr, input logic [31:0] dwd, input logic [31:0] a,
                     input logic [31:0] alu, input logic [31:0] ext, input logic [31:0] o1,
                     input logic [31:0] o2, input logic mw, input logic m2r, input logic ca);
    vec_t v;
    v.instr = instr; v.dwd = dwd; v.addr = a; v.alu = alu; v.ext = ext;
    v.out1 = o1; v.out2 = o2; v.mw = mw; v.m2r = m2r; v.chk_alu = ca;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    // PC 0x00..0x1C: immediates, R-type arithmetic, store and load
    add(enc_i('h08, 0, 1, 'h0005), 0, 32'h00, 32'h5, 32'h5, 0, 0, 0, 0, 1);
    add(enc_i('h08, 0, 2, 'hFFFF), 0, 32'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 1);
    add(enc_r(1, 2, 3, 0, 'h20), 0, 32'h08, 32'h4, 32'h1820, 32'h5, 32'hFFFF_FFFF, 0, 0, 1);
    add(enc_r(2, 1, 4, 0, 'h2A), 0, 32'h0C, 32'h1, 32'h202A, 32'hFFFF_FFFF, 32'h5, 0, 0, 1);
    add(enc_i('h0D, 0, 5, 'h8000), 0, 32'h10, 32'h8000, 32'h8000, 0, 0, 0, 0, 1);
    add(enc_i('h08, 0, 2, 'h0010), 0, 32'h14, 32'h10, 32'h10, 0, 32'hFFFF_FFFF, 0, 0, 1);
    add(enc_i('h2B, 2, 1, 'h0004), 0, 32'h18, 32'h14, 32'h4, 32'h10, 32'h5, 1, 0, 1);
    add(enc_i('h23, 2, 6, 'h0000), 32'h1234_5678, 32'h1C, 32'h10, 32'h0, 32'h10, 0, 0, 1, 1);
    // Control flow: 0x20 -> 0x30 -> 0x34 -> 0x40 -> 0x4C -> 0x20 -> 0x24
    add(enc_i('h04, 1, 1, 'h0003), 0, 32'h20, 0, 32'h3, 32'h5, 32'h5, 0, 0, 0);
    add(enc_i('h05, 1, 1, 'h0003), 0, 32'h30, 0, 32'h3, 32'h5, 32'h5, 0, 0, 0);
    add(32'h0800_0010, 0, 32'h34, 0, 32'h10, 0, 0, 0, 0, 0);
    add(enc_i('h05, 1, 2, 'h0002), 0, 32'h40, 0, 32'h2, 32'h5, 32'h10, 0, 0, 0);
    add(enc_i('h04, 0, 0, 'hFFF4), 0, 32'h4C, 0, 32'hFFFF_FFF4, 0, 0, 0, 0, 0);
    add(enc_i('h05, 1, 1, 'h0003), 0, 32'h20, 0, 32'h3, 32'h5, 32'h5, 0, 0, 0);
    // $0 write discarded, lw result readable, unsupported opcode is a NOP
    add(enc_i('h08, 0, 0, 'h0007), 0, 32'h24, 32'h7, 32'h7, 0, 0, 0, 0, 1);
    add(enc_r(0, 6, 7, 0, 'h20), 0, 32'h28, 32'h1234_5678, 32'h3820, 0, 32'h1234_5678, 0, 0, 1);
    add({6'h3F, 5'd1, 5'd2, 16'h0004}, 0, 32'h2C, 0, 32'h4, 32'h5, 32'h10, 0, 0, 0);
    // Shifts, lui, remaining logic ops
    add(enc_r(0, 1, 8, 3, 'h00), 0, 32'h30, 32'h28, 32'h40C0, 0, 32'h5, 0, 0, 1);
    add(enc_r(0, 2, 9, 2, 'h02), 0, 32'h34, 32'h4, 32'h4882, 0, 32'h10, 0, 0, 1);
    add(enc_i('h0F, 0, 10, 'hABCD), 0, 32'h38, 32'hABCD_0000, 32'hABCD_0000, 0, 0, 0, 0, 1);
    add(enc_r(1, 2, 11, 0, 'h22), 0, 32'h3C, 32'hFFFF_FFF5, 32'h5822, 32'h5, 32'h10, 0, 0, 1);
    add(enc_r(1, 2, 12, 0, 'h27), 0, 32'h40, 32'hFFFF_FFEA, 32'h6027, 32'h5, 32'h10, 0, 0, 1);
    add(enc_i('h0C, 10, 13, 'hFFFF), 0, 32'h44, 32'h0, 32'h0000_FFFF, 32'hABCD_0000, 0, 0, 0, 1);
    add(enc_i('h0A, 2, 14, 'hFFFF), 0, 32'h48, 32'h0, 32'hFFFF_FFFF, 32'h10, 0, 0, 0, 1);
    add(enc_r(1, 10, 15, 0, 'h26), 0, 32'h4C, 32'hABCD_0005, 32'h7826, 32'h5, 32'hABCD_0000, 0, 0, 1);
    add(enc_i('h0E, 1, 16, 'hFFFF), 0, 32'h50, 32'hFFFA, 32'h0000_FFFF, 32'h5, 0, 0, 0, 1);
    add(enc_r(11, 0, 17, 0, 'h25), 0, 32'h54, 32'hFFFF_FFF5, 32'hFFFF_8825, 32'hFFFF_FFF5, 0, 0, 0, 1);
    add(enc_i('h04, 11, 17, 'h0001), 0, 32'h58, 0, 32'h1, 32'hFFFF_FFF5, 32'hFFFF_FFF5, 0, 0, 0);
    add(32'h0800_0010, 0, 32'h60, 0, 32'h10, 0, 0, 0, 0, 0);
    // Same-cycle read of the register being written returns the old value
    add(enc_i('h08, 1, 1, 'h0001), 0, 32'h40, 32'h6, 32'h1, 32'h5, 32'h5, 0, 0, 1);
    add(enc_r(1, 0, 20, 0, 'h20), 0, 32'h44, 32'h6, 32'hFFFF_A020, 32'h6, 0, 0, 0, 1);

    Reset = 1'b1;
    Instruction = enc_i('h2B, 2, 1, 'h0004);
    DataToWd = 32'h0;
    for (int e = 0; e < 2; e++) begin
      @(posedge Clock);
      #1;
      check($sformatf("reset%0d", e), {addr, Out1, Out2, 31'h0, MemWrite},
            {32'h0, 32'h0, 32'h0, 32'h0});
    end

    for (int i = 0; i < vecs.size(); i++) begin
      logic ok;
      @(negedge Clock);
      Reset = 1'b0;
      Instruction = vecs[i].instr;
      DataToWd = vecs[i].dwd;
      #1;
      ok = (addr === vecs[i].addr) && (Ext_Imm === vecs[i].ext) && (Out1 === vecs[i].out1) &&
           (Out2 === vecs[i].out2) && (MemWrite === vecs[i].mw) && (MemtoReg === vecs[i].m2r) &&
           (!vecs[i].chk_alu || ALU_result === vecs[i].alu);
      n_vec++;
      if (!ok) begin
        n_bad++;
        $display("FAIL vec%0d: got addr=%h alu=%h ext=%h o1=%h o2=%h mw=%b m2r=%b want addr=%h alu=%h ext=%h o1=%h o2=%h mw=%b m2r=%b",
                 i, addr, ALU_result, Ext_Imm, Out1, Out2, MemWrite, MemtoReg,
                 vecs[i].addr, vecs[i].alu, vecs[i].ext, vecs[i].out1, vecs[i].out2,
                 vecs[i].mw, vecs[i].m2r);
      end
    end

    // Mid-program reset while a store is presented
    @(negedge Clock);
    Reset = 1'b1;
    Instruction = enc_i('h2B, 2, 1, 'h0004);
    DataToWd = 32'h0;
    #1;
    check("midreset_pre", {addr, 31'h0, MemWrite}, {32'h48, 32'h0});

    for (int k = 0; k < 16; k++) begin
      @(negedge Clock);
      Reset = 1'b0;
      Instruction = {6'h3F, 5'(2 * k), 5'(2 * k + 1), 16'h0};
      #1;
      check($sformatf("post_reset%0d", k), {addr, Out1, Out2, 30'h0, MemWrite, MemtoReg},
            {32'(4 * k), 32'h0, 32'h0, 32'h0});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
